// File: rtl/keypad_scanner.sv
// Row-scanned 4x4 matrix keypad controller.
// Drives one keypad row low at a time, samples the synchronized column lines
// once per scan tick, debounces presses and releases, and reports the
// accepted key as {row, col} with a one-cycle valid pulse and a held level.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]    DB_TARGET = DB_W'(DEBOUNCE_CNT);
  localparam logic [DB_W-1:0]    DB_ONE    = DB_W'(1);

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_e;

  // Column synchronizer
  logic [3:0]         col_meta_q, col_meta_d;
  logic [3:0]         col_s_q,    col_s_d;

  // Scan-rate prescaler
  logic [PRESC_W-1:0] presc_q,    presc_d;
  logic               tick;

  // Scanner FSM and datapath
  state_e             state_q,    state_d;
  logic [1:0]         row_idx_q,  row_idx_d;
  logic [1:0]         col_idx_q,  col_idx_d;
  logic [DB_W-1:0]    db_cnt_q,   db_cnt_d;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;

  // Helper terms
  logic [1:0]         det_col;
  logic               cap_low;
  logic [DB_W-1:0]    db_inc;
  logic               db_done;

  // Synchronizer shift and prescaler next values
  always_comb begin
    col_meta_d = key_col;
    col_s_d    = col_meta_q;
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + 1'b1;
  end

  // Lowest-index low column, captured-column level and debounce arithmetic
  always_comb begin
    if (!col_s_q[0]) begin
      det_col = 2'd0;
    end else if (!col_s_q[1]) begin
      det_col = 2'd1;
    end else if (!col_s_q[2]) begin
      det_col = 2'd2;
    end else begin
      det_col = 2'd3;
    end
    cap_low = ~col_s_q[col_idx_q];
    db_inc  = db_cnt_q + 1'b1;
    db_done = (db_inc == DB_TARGET);
  end

  // State register and all datapath flops
  always_ff @(posedge clock) begin
    if (!reset) begin
      col_meta_q  <= '1;
      col_s_q     <= '1;
      presc_q     <= '0;
      state_q     <= SCAN;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      db_cnt_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      col_meta_q  <= col_meta_d;
      col_s_q     <= col_s_d;
      presc_q     <= presc_d;
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state and datapath updates; everything moves only on a scan tick,
  // while key_valid self-clears every cycle it is not re-armed.
  // The valid pulse and code are registered on the tick that enters HELD
  // from SCAN/PRESS_DB, so they appear in the first HELD cycle; re-entry
  // from RELEASE_DB deliberately leaves them untouched.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    db_cnt_d    = db_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (col_s_q != 4'hF) begin
            col_idx_d = det_col;
            db_cnt_d  = DB_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_d     = HELD;
              key_code_d  = {row_idx_q, det_col};
              key_valid_d = 1'b1;
            end else begin
              state_d = PRESS_DB;
            end
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end

        PRESS_DB: begin
          if (cap_low) begin
            db_cnt_d = db_inc;
            if (db_done) begin
              state_d     = HELD;
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
            end
          end else begin
            state_d   = SCAN;
            db_cnt_d  = '0;
            row_idx_d = row_idx_q + 2'd1;
          end
        end

        HELD: begin
          if (!cap_low) begin
            if (DEBOUNCE_CNT == 1) begin
              state_d   = SCAN;
              db_cnt_d  = '0;
              row_idx_d = row_idx_q + 2'd1;
            end else begin
              state_d  = RELEASE_DB;
              db_cnt_d = DB_ONE;
            end
          end
        end

        RELEASE_DB: begin
          if (!cap_low) begin
            db_cnt_d = db_inc;
            if (db_done) begin
              state_d   = SCAN;
              db_cnt_d  = '0;
              row_idx_d = row_idx_q + 2'd1;
            end
          end else begin
            state_d = HELD;
          end
        end

        default: begin
          state_d = SCAN;
        end
      endcase
    end
  end

  // Output decode: one-cold row drive and held level from the state
  always_comb begin
    key_row   = ~(4'b0001 << row_idx_q);
    key_held  = (state_q == HELD) || (state_q == RELEASE_DB);
    key_code  = key_code_q;
    key_valid = key_valid_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_CNT = 3.
// A passive 4x4 switch matrix turns the DUT row drive plus the pressed-key
// map into column levels; expected key reports are queued when a press is
// applied and checked when key_valid pulses.
module tb_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;

  typedef struct {
    logic [3:0]  code;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned k;
  int unsigned vectors;
  int unsigned miscompares;
  int unsigned k0;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Switch matrix: a column reads low when a pressed key sits on a driven-low row
  assign key_col[0] = ~|(~key_row & {pressed[12], pressed[8], pressed[4], pressed[0]});
  assign key_col[1] = ~|(~key_row & {pressed[13], pressed[9], pressed[5], pressed[1]});
  assign key_col[2] = ~|(~key_row & {pressed[14], pressed[10], pressed[6], pressed[2]});
  assign key_col[3] = ~|(~key_row & {pressed[15], pressed[11], pressed[7], pressed[3]});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock; k counts rising edges since reset release; valid pulses are scored
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    if (reset) k++;
    if (key_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {31'd0, key_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("valid_code", {28'd0, key_code}, {28'd0, e.code});
        check("valid_cycle", k, e.cyc);
      end
    end
  endtask

  // Wait for the scan to land on a row right after the tick that selected it
  task automatic wait_row(input logic [3:0] target);
    int unsigned n;
    n = 0;
    while (!(key_row === target && (k % 4) == 0) && n < 64) begin
      cycle();
      n++;
    end
    check("wait_row", {28'd0, key_row}, {28'd0, target});
  endtask

  task automatic align_tick();
    while ((k % 4) != 0) cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] er;
    vectors     = 0;
    miscompares = 0;
    k           = 0;
    pressed     = '0;
    reset       = 1'b0;

    // Reset state
    repeat (3) cycle();
    check("rst_row",   {28'd0, key_row},   32'he);
    check("rst_code",  {28'd0, key_code},  32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held",  {31'd0, key_held},  32'd0);
    reset = 1'b1;
    k     = 0;

    // Idle scan: each row low for 4 cycles in turn
    for (int unsigned i = 0; i < 20; i++) begin
      cycle();
      er = ~(4'b0001 << ((k / 4) % 4));
      check("idle_row", {28'd0, key_row}, {28'd0, er});
    end

    // Stable press row 2 / col 1
    wait_row(4'b1011);
    pressed[9] = 1'b1;
    sb.push_back('{4'd9, k + 12});
    repeat (12) cycle();
    check("k9_held", {31'd0, key_held}, 32'd1);
    check("k9_code", {28'd0, key_code}, 32'd9);
    check("k9_pulse_seen", sb.size(), 32'd0);
    for (int unsigned i = 0; i < 16; i++) begin
      cycle();
      check("k9_row_frozen", {28'd0, key_row}, 32'hb);
    end
    align_tick();
    pressed[9] = 1'b0;
    repeat (11) cycle();
    check("k9_held_rel_db", {31'd0, key_held}, 32'd1);
    cycle();
    check("k9_released", {31'd0, key_held}, 32'd0);
    check("k9_next_row", {28'd0, key_row}, 32'h7);
    check("k9_code_kept", {28'd0, key_code}, 32'd9);

    // One-tick bounce on row 1 / col 0
    wait_row(4'b1101);
    pressed[4] = 1'b1;
    repeat (4) cycle();
    check("bounce_row_frozen", {28'd0, key_row}, 32'hd);
    pressed[4] = 1'b0;
    repeat (4) cycle();
    check("bounce_row_next", {28'd0, key_row}, 32'hb);
    check("bounce_held",     {31'd0, key_held}, 32'd0);
    check("bounce_code",     {28'd0, key_code}, 32'd9);

    // Row 0, columns 3 and 1 together; then a key on row 3 while held
    wait_row(4'b1110);
    pressed[3] = 1'b1;
    pressed[1] = 1'b1;
    sb.push_back('{4'd1, k + 12});
    repeat (12) cycle();
    check("multi_code", {28'd0, key_code}, 32'd1);
    check("multi_held", {31'd0, key_held}, 32'd1);
    pressed[12] = 1'b1;
    repeat (16) cycle();
    check("ignore_code", {28'd0, key_code}, 32'd1);
    check("ignore_row",  {28'd0, key_row},  32'he);
    check("ignore_held", {31'd0, key_held}, 32'd1);
    check("ignore_no_pulse", sb.size(), 32'd0);

    // Release with a one-tick re-close during release debounce
    align_tick();
    k0 = k;
    pressed[3]  = 1'b0;
    pressed[1]  = 1'b0;
    pressed[12] = 1'b0;
    repeat (4) cycle();
    pressed[1] = 1'b1;
    repeat (4) cycle();
    check("glitch_held", {31'd0, key_held}, 32'd1);
    pressed[1] = 1'b0;
    repeat (11) cycle();
    check("glitch_held_late", {31'd0, key_held}, 32'd1);
    check("glitch_timing", k - k0, 32'd19);
    cycle();
    check("glitch_released", {31'd0, key_held}, 32'd0);
    check("glitch_next_row", {28'd0, key_row},  32'hd);
    check("glitch_code",     {28'd0, key_code}, 32'd1);

    // Reset during press debounce, key still held afterwards
    wait_row(4'b1011);
    pressed[10] = 1'b1;
    repeat (6) cycle();
    check("pdb_row_frozen", {28'd0, key_row}, 32'hb);
    reset = 1'b0;
    repeat (3) cycle();
    check("mid_rst_row",   {28'd0, key_row},   32'he);
    check("mid_rst_code",  {28'd0, key_code},  32'd0);
    check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_held",  {31'd0, key_held},  32'd0);
    reset = 1'b1;
    k     = 0;
    sb.push_back('{4'd10, 32'd20});
    repeat (24) cycle();
    check("redetect_code", {28'd0, key_code}, 32'd10);
    check("redetect_held", {31'd0, key_held}, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clock cycles per scan tick (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 4: consecutive stable scan ticks needed to accept a press or a release (minimum 1).
REQ-003 The block SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port key_col  input  4  keypad column lines; active-low, externally pulled up, asynchronous to clock.
REQ-006 The block SHALL have port key_row  output  4  keypad row drive; active-low, at most one row low.
REQ-007 The block SHALL have port key_code  output  4  code of the last accepted key, row*4+col.
REQ-008 The block SHALL have port key_valid  output  1  one-cycle pulse on press acceptance.
REQ-009 The block SHALL have port key_held  output  1  high while an accepted key stays pressed.

Function
REQ-010 key_col SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan tick is asserted for the one cycle when the count equals SCAN_DIV-1.
REQ-012 All state transitions and counter updates below SHALL occur only on scan-tick cycles, except the key_valid clear.
REQ-013 key_row SHALL equal the bitwise inverse of (1 << row_idx), row_idx 2 bits.
REQ-014 The FSM SHALL have states SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-015 SCAN, tick, col_s == 4'hF: row_idx increments, wrapping 3 -> 0.
REQ-016 SCAN, tick, col_s != 4'hF: capture row_idx and col_idx = lowest-index low bit of col_s; debounce count = 1; go PRESS_DB; row_idx frozen.
REQ-017 PRESS_DB, tick, captured column low: increment debounce count; when count reaches DEBOUNCE_CNT, go HELD.
REQ-018 PRESS_DB, tick, captured column high: go SCAN, row_idx increments (wrap), no output change.
REQ-019 With DEBOUNCE_CNT = 1, the SCAN detection tick SHALL go directly to HELD.
REQ-020 On entry to HELD: key_code = {row_idx, col_idx} and key_valid = 1 for exactly one clock cycle; key_held = 1 from that cycle.
REQ-021 HELD, tick, captured column high: debounce count = 1, go RELEASE_DB (if DEBOUNCE_CNT = 1, go SCAN directly).
REQ-022 RELEASE_DB, tick, captured column high: increment count; at DEBOUNCE_CNT go SCAN, key_held = 0, row_idx increments.
REQ-023 RELEASE_DB, tick, captured column low: return to HELD, no new key_valid.
REQ-024 key_held SHALL be 1 in HELD and RELEASE_DB, 0 otherwise.
REQ-025 Other keys pressed while not in SCAN SHALL be ignored; several low columns in one row resolve to the lowest index.
REQ-026 key_code SHALL hold its value until the next accepted press.
REQ-027 key_row SHALL be stable except at row advances; latency from a stable press on the scanned row to key_valid is DEBOUNCE_CNT ticks after detection, plus one cycle.

Reset
REQ-028 While reset = 0 at a clock edge: state SCAN, row_idx 0 (key_row = 4'b1110), prescaler 0, debounce count 0, synchronizer 4'hF, key_code 0, key_valid 0, key_held 0.
REQ-029 Reset asserted mid-press or mid-debounce SHALL abort without a key_valid pulse; a key still held after release of reset is detected afresh.

Verification (SCAN_DIV = 4, DEBOUNCE_CNT = 3)
REQ-030 Reset then no keys -> key_row cycles 1110, 1101, 1011, 0111, 1110, each for 4 cycles; key_valid never high.
REQ-031 Hold row 2/col 1 stable -> key_valid single pulse, key_code = 9, key_held = 1; key_row stays 1011 until release.
REQ-032 Row 1/col 0 low for only 1 tick (bounce) -> return to SCAN, no key_valid, key_code unchanged.
REQ-033 Row 0, cols 3 and 1 low together -> key_code = 1; a second key on row 3 while held -> ignored.
REQ-034 Release with a 1-tick re-close glitch during RELEASE_DB -> back to HELD, no second pulse; clean release for 3 ticks -> key_held = 0, scanning resumes at next row.
REQ-035 Reset asserted during PRESS_DB -> all outputs to REQ-028 values, key_row = 1110, no key_valid.
